reg_operand_fetch: RTL and testbench
====================================

REG_OPERAND_FETCH -- requirements
Module: reg_operand_fetch

Interface
REQ-001 SHALL have no parameters; widths come from pkg_reg::REG_WIDTH and pkg_reg::REG_DEPTH, with address width $clog2(REG_DEPTH).
REQ-002 Port clk: input, 1 bit; the single clock, rising edge.
REQ-003 Port rst_n: input, 1 bit; asynchronous, active-low reset.
REQ-004 Port reg_file: if_reg_file.client; drives op, addr_in, data_in, addr_out0 and addr_out1, and receives data_out0 and data_out1.
REQ-005 Ports req_valid (in, 1), req_ready (out, 1), req_src0 (in, addr), req_src1 (in, addr); the operand-fetch request channel.
REQ-006 Ports out_valid (out, 1), out_ready (in, 1), out_op0 (out, REG_WIDTH), out_op1 (out, REG_WIDTH); the operand result channel.
REQ-007 Ports wb_valid (in, 1), wb_addr (in, addr), wb_data (in, REG_WIDTH); the writeback channel, which is always accepted.

Function
REQ-008 SHALL implement the FSM states IDLE, ISSUE, CAPTURE and VALID.
REQ-009 In IDLE, req_ready SHALL be 1; a handshake (req_valid & req_ready) SHALL register both sources and move the FSM to ISSUE.
REQ-010 In ISSUE, addr_out0 and addr_out1 SHALL carry the registered sources, so the server samples them at the end of ISSUE; next state is CAPTURE.
REQ-011 In CAPTURE, data_out0 and data_out1 SHALL be loaded into out_op0 and out_op1, after any bypass; next state is VALID.
REQ-012 In VALID, out_valid SHALL be 1 with stable operands; on out_ready the FSM SHALL go to IDLE.
REQ-013 Latency SHALL be exactly 3 cycles from the accepting edge to out_valid=1; throughput is one request per 4 cycles at best.
REQ-014 req_ready SHALL be 0 in ISSUE, CAPTURE and VALID; there is no request-side buffering.
REQ-015 Writeback: when wb_valid=1, op=pkg_reg::REG_WRITE, addr_in=wb_addr and data_in=wb_data in that same cycle, in any FSM state.
REQ-016 When wb_valid=0, op SHALL be pkg_reg::REG_NOP.
REQ-017 A writeback to address 0 SHALL still be issued; the server discards it.
REQ-018 A writeback in the ISSUE cycle whose address matches a source is a read-during-write hazard: the server returns the old value.
REQ-019 Operands SHALL reflect register state as of the end of ISSUE; writebacks during CAPTURE or VALID SHALL NOT alter the held operands.
REQ-020 A source equal to 0 SHALL yield 0 regardless of any writeback.

Reset
REQ-021 While rst_n=0, the FSM SHALL be in IDLE and out_valid=0.
REQ-022 While rst_n=0, out_op0, out_op1 and the registered sources SHALL be 0, and op SHALL be REG_NOP.
REQ-023 Reset asserted mid-operation SHALL drop the in-flight request; no out_valid follows it.
REQ-024 req_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.

Configuration
REQ-025 With macro REG_BYPASS_EN defined, a hazard (REQ-018) SHALL forward the ISSUE-cycle wb_data into the matching operand at CAPTURE, per source independently; latency is unchanged.
REQ-026 Without REG_BYPASS_EN, the FSM SHALL stay in ISSUE (re-issuing the same addresses) in any cycle where wb_valid=1 and wb_addr is nonzero and matches a source.
REQ-027 Without REG_BYPASS_EN, latency SHALL grow by one cycle per stalled cycle.

Structure
REQ-028 pkg_reg SHALL hold REG_WIDTH, REG_DEPTH, the reg op enum (REG_NOP, REG_WRITE) and a typedef for the register address.
REQ-029 The FSM state enum SHALL be local to reg_operand_fetch.
REQ-030 Verification pairs reg_operand_fetch with dev_reg_file through if_reg_file.
REQ-031 No sub-module SHALL be used; the bypass comparator is inline logic.

Verification
REQ-032 Write r3=0x11 via wb, then request (3,0) -> out_valid 3 cycles after accept; op0=0x11, op1=0.
REQ-033 Request (5,5) with out_ready held low for 4 cycles -> out_valid stays 1, operands stable, req_ready=0; on release, idle the next cycle.
REQ-034 Request (7,2) with wb r7=0xAB during ISSUE (old r7=0x01) -> bypass build: op0=0xAB with 3-cycle latency; non-bypass build: op0=0xAB with 4-cycle latency.
REQ-035 Writeback to r0=0xFF, then request (0,0) -> both operands 0.
REQ-036 rst_n pulsed low during CAPTURE -> out_valid never asserts; req_ready=1 the first cycle after release; the next request completes normally.
REQ-037 Writeback r4=0x22 during VALID of a request reading r4 (old 0x09) -> held op0 remains 0x09.

Source files
------------

// File: rtl/reg_operand_fetch_pkg.sv
// Shared register-file types: data/address widths and the write-port op code.
// Imported by the interface, the register-file model and the fetch stage.
package pkg_reg;

   localparam int REG_WIDTH = 32;
   localparam int REG_DEPTH = 32;
   localparam int REG_AW    = $clog2(REG_DEPTH);

   typedef logic [REG_AW-1:0]    reg_addr_t;
   typedef logic [REG_WIDTH-1:0] reg_data_t;

   typedef enum logic {
      REG_NOP   = 1'b0,
      REG_WRITE = 1'b1
   } reg_op_e;

endpackage

// File: rtl/if_reg_file.sv
// Register-file port bundle: one write port, two registered read ports.
// The client drives addresses and write data; the server returns read data.
interface if_reg_file
   import pkg_reg::*;
   ;

   reg_op_e   op;
   reg_addr_t addr_in;
   reg_data_t data_in;
   reg_addr_t addr_out0;
   reg_addr_t addr_out1;
   reg_data_t data_out0;
   reg_data_t data_out1;

   modport client (
      output op, addr_in, data_in, addr_out0, addr_out1,
      input  data_out0, data_out1
   );

   modport server (
      input  op, addr_in, data_in, addr_out0, addr_out1,
      output data_out0, data_out1
   );

endinterface

// File: rtl/dev_reg_file.sv
// Register-file server: synchronous write, registered reads that return
// the pre-write value on a same-cycle hit; r0 always reads as zero.
module dev_reg_file
   import pkg_reg::*;
(
   input logic        clk,
   input logic        rst_n,
   if_reg_file.server reg_file
);

   reg_data_t mem_q [REG_DEPTH];

   // write port; writes to r0 are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (reg_file.op == REG_WRITE &&
                   reg_file.addr_in != '0) begin
         mem_q[reg_file.addr_in] <= reg_file.data_in;
      end
   end

   // read ports sample the address at the edge and see old contents
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_file.data_out0 <= '0;
         reg_file.data_out1 <= '0;
      end else begin
         reg_file.data_out0 <= (reg_file.addr_out0 == '0) ?
                               '0 : mem_q[reg_file.addr_out0];
         reg_file.data_out1 <= (reg_file.addr_out1 == '0) ?
                               '0 : mem_q[reg_file.addr_out1];
      end
   end

endmodule

// File: rtl/reg_operand_fetch.sv
// Operand fetch: IDLE -> ISSUE -> CAPTURE -> VALID, with writeback passthrough.
// REG_BYPASS_EN forwards an ISSUE-cycle writeback hit; otherwise ISSUE stalls.
module reg_operand_fetch
   import pkg_reg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   if_reg_file.client           reg_file,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [REG_AW-1:0]    req_src0,
   input  logic [REG_AW-1:0]    req_src1,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [REG_WIDTH-1:0] out_op0,
   output logic [REG_WIDTH-1:0] out_op1,
   input  logic                 wb_valid,
   input  logic [REG_AW-1:0]    wb_addr,
   input  logic [REG_WIDTH-1:0] wb_data
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      VALID   = 2'd3
   } state_e;

   state_e    state_q, state_d;
   reg_addr_t src0_q, src0_d;
   reg_addr_t src1_q, src1_d;
   reg_data_t op0_q, op0_d;
   reg_data_t op1_q, op1_d;
   logic      hit0, hit1;
   reg_data_t fwd0, fwd1;

   // writeback colliding with a nonzero source being read this cycle
   assign hit0 = wb_valid && (wb_addr != '0) && (wb_addr == src0_q);
   assign hit1 = wb_valid && (wb_addr != '0) && (wb_addr == src1_q);

`ifdef REG_BYPASS_EN
   logic      byp0_q, byp1_q;
   reg_data_t byp_data_q;

   // remember which operands the ISSUE-cycle writeback must override
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byp0_q     <= 1'b0;
         byp1_q     <= 1'b0;
         byp_data_q <= '0;
      end else if (state_q == ISSUE) begin
         byp0_q     <= hit0;
         byp1_q     <= hit1;
         byp_data_q <= wb_data;
      end
   end

   assign fwd0 = byp0_q ? byp_data_q : reg_file.data_out0;
   assign fwd1 = byp1_q ? byp_data_q : reg_file.data_out1;
`else
   assign fwd0 = reg_file.data_out0;
   assign fwd1 = reg_file.data_out1;
`endif

   // state, source and operand registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         src0_q  <= '0;
         src1_q  <= '0;
         op0_q   <= '0;
         op1_q   <= '0;
      end else begin
         state_q <= state_d;
         src0_q  <= src0_d;
         src1_q  <= src1_d;
         op0_q   <= op0_d;
         op1_q   <= op1_d;
      end
   end

   // next-state and capture logic
   always_comb begin
      state_d = state_q;
      src0_d  = src0_q;
      src1_d  = src1_q;
      op0_d   = op0_q;
      op1_d   = op1_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               src0_d  = req_src0;
               src1_d  = req_src1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
`ifdef REG_BYPASS_EN
            state_d = CAPTURE;
`else
            if (!(hit0 || hit1)) begin
               state_d = CAPTURE;
            end
`endif
         end
         CAPTURE: begin
            op0_d   = fwd0;
            op1_d   = fwd1;
            state_d = VALID;
         end
         VALID: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready = rst_n && (state_q == IDLE);
   assign out_valid = (state_q == VALID);
   assign out_op0   = op0_q;
   assign out_op1   = op1_q;

   assign reg_file.op        = (rst_n && wb_valid) ? REG_WRITE : REG_NOP;
   assign reg_file.addr_in   = wb_addr;
   assign reg_file.data_in   = wb_data;
   assign reg_file.addr_out0 = src0_q;
   assign reg_file.addr_out1 = src1_q;

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Scoreboard bench for reg_operand_fetch paired with dev_reg_file.
// Requests push expectations; a monitor pops them when out_valid rises.
module tb_reg_operand_fetch;
   import pkg_reg::*;

   typedef struct {
      logic [31:0] e0;
      logic [31:0] e1;
      int          lat;
      int          acc;
   } exp_t;

`ifdef REG_BYPASS_EN
   localparam int HZ_LAT = 3;
`else
   localparam int HZ_LAT = 4;
`endif

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 req_valid, req_ready;
   logic [REG_AW-1:0]    req_src0, req_src1;
   logic                 out_valid, out_ready;
   logic [REG_WIDTH-1:0] out_op0, out_op1;
   logic                 wb_valid;
   logic [REG_AW-1:0]    wb_addr;
   logic [REG_WIDTH-1:0] wb_data;

   int   nvec = 0;
   int   nmis = 0;
   int   cyc  = 0;
   exp_t sbq[$];

   if_reg_file rf ();

   dev_reg_file u_rf (
      .clk      (clk),
      .rst_n    (rst_n),
      .reg_file (rf.server)
   );

   reg_operand_fetch dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .reg_file  (rf.client),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_src0  (req_src0),
      .req_src1  (req_src1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_op0   (out_op0),
      .out_op1   (out_op1),
      .wb_valid  (wb_valid),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // monitor: pops on the first VALID cycle, checks hold every cycle
   initial begin
      exp_t cur;
      bit   act;
      act = 1'b0;
      cur = '{e0: 0, e1: 0, lat: 0, acc: 0};
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            act = 1'b0;
         end else if (out_valid) begin
            if (!act) begin
               if (sbq.size() == 0) begin
                  nvec++;
                  nmis++;
                  $display("FAIL spurious_out_valid: got 1 want 0");
               end else begin
                  cur = sbq.pop_front();
                  act = 1'b1;
                  chk("latency", cyc - cur.acc, cur.lat);
               end
            end
            if (act) begin
               chk("op0", out_op0, cur.e0);
               chk("op1", out_op1, cur.e1);
            end
            if (out_ready) act = 1'b0;
         end
      end
   end

   task automatic wb(input logic [REG_AW-1:0] a, input logic [31:0] d);
      @(negedge clk);
      wb_valid = 1'b1;
      wb_addr  = a;
      wb_data  = d;
      #1;
      chk("wb_op", rf.op, REG_WRITE);
      chk("wb_addr_in", rf.addr_in, a);
      chk("wb_data_in", rf.data_in, d);
      @(negedge clk);
      wb_valid = 1'b0;
   endtask

   task automatic wait_valid();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         #1;
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         nvec++;
         nmis++;
         $display("FAIL timeout: got no out_valid want out_valid=1");
      end
   endtask

   // issue a request; optional writeback lands in the ISSUE cycle
   task automatic do_req(input logic [REG_AW-1:0] s0, s1,
                         input logic [31:0] e0, e1, input int lat,
                         input bit hz, input logic [REG_AW-1:0] ha,
                         input logic [31:0] hd);
      @(negedge clk);
      req_valid = 1'b1;
      req_src0  = s0;
      req_src1  = s1;
      sbq.push_back('{e0: e0, e1: e1, lat: lat, acc: cyc});
      @(negedge clk);
      req_valid = 1'b0;
      if (hz) begin
         wb_valid = 1'b1;
         wb_addr  = ha;
         wb_data  = hd;
         @(negedge clk);
         wb_valid = 1'b0;
      end
      wait_valid();
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_src0  = '0;
      req_src1  = '0;
      out_ready = 1'b1;
      wb_valid  = 1'b1;
      wb_addr   = 5'd9;
      wb_data   = 32'hDEAD;
      @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_op_nop", rf.op, REG_NOP);
      chk("rst_out_op0", out_op0, 0);
      wb_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_req_ready", req_ready, 1);
      chk("idle_op_nop", rf.op, REG_NOP);

      wb(5'd3, 32'h11);
      do_req(5'd3, 5'd0, 32'h11, 32'h0, 3, 1'b0, 5'd0, 0);
      @(negedge clk);

      wb(5'd5, 32'h55);
      out_ready = 1'b0;
      do_req(5'd5, 5'd5, 32'h55, 32'h55, 3, 1'b0, 5'd0, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         chk("hold_req_ready", req_ready, 0);
         chk("hold_out_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("release_req_ready", req_ready, 1);
      chk("release_out_valid", out_valid, 0);

      wb(5'd7, 32'h01);
      do_req(5'd7, 5'd2, 32'hAB, 32'h0, HZ_LAT, 1'b1, 5'd7, 32'hAB);
      @(negedge clk);

      do_req(5'd0, 5'd1, 32'h0, 32'h0, 3, 1'b1, 5'd0, 32'h77);
      @(negedge clk);

      wb(5'd0, 32'hFF);
      do_req(5'd0, 5'd0, 32'h0, 32'h0, 3, 1'b0, 5'd0, 0);
      @(negedge clk);

      wb(5'd4, 32'h09);
      out_ready = 1'b0;
      do_req(5'd4, 5'd3, 32'h09, 32'h11, 3, 1'b0, 5'd0, 0);
      wb(5'd4, 32'h22);
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      do_req(5'd4, 5'd4, 32'h22, 32'h22, 3, 1'b0, 5'd0, 0);
      @(negedge clk);

      @(negedge clk);
      req_valid = 1'b1;
      req_src0  = 5'd3;
      req_src1  = 5'd3;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_req_ready", req_ready, 0);
      chk("midrst_out_op0", out_op0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrel_req_ready", req_ready, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         chk("dropped_out_valid", out_valid, 0);
      end

      wb(5'd6, 32'h66);
      do_req(5'd6, 5'd0, 32'h66, 32'h0, 3, 1'b0, 5'd0, 0);
      @(negedge clk);
      @(negedge clk);
      chk("sb_empty", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
